// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle main-control FSM.
// Contents:
//   - opcode constants (6-bit; callers zero-extend them to their opcode width)
//   - state encoding (4 bits, also exported on the debug 'state' port)
//   - aluop / alusrcb / pcsource / bcond_sel encodings
//   - one-hot opcode class indices
//   - ctrl_t, the Moore output bundle, and state_outputs(), which maps a state to its outputs
package ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BEN  = 6'b000110;
    localparam logic [5:0] OP_BVF  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] BC_ZERO = 2'b00;
    localparam logic [1:0] BC_NEG  = 2'b01;
    localparam logic [1:0] BC_OVF  = 2'b10;

    localparam int CLS_W    = 7;
    localparam int CLS_R    = 0;
    localparam int CLS_LW   = 1;
    localparam int CLS_SW   = 2;
    localparam int CLS_BR   = 3;
    localparam int CLS_J    = 4;
    localparam int CLS_ADDI = 5;
    localparam int CLS_ILL  = 6;

    // 'fetch' marks the FETCH state; irwrite and the fetch-time pcwrite
    // are formed outside the register by gating it with mem_ready.
    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       fetch;
    } ctrl_t;

    function automatic ctrl_t state_outputs(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memread  = 1'b1;
                c.alusrcb  = SRCB_FOUR;
                c.fetch    = 1'b1;
            end
            S_DECODE: c.alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_REXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_B;
                c.aluop   = ALUOP_FUNCT;
            end
            S_RWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            S_ADDIWB: c.regwrite = 1'b1;
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.alusrcb     = SRCB_B;
                c.aluop       = ALUOP_SUB;
                c.pcwritecond = 1'b1;
                c.pcsource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pcwrite  = 1'b1;
                c.pcsource = PCSRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/opcode_class_decoder.sv
// Combinational opcode classifier for the multicycle control FSM.
// Ports:
//   opcode  in  OPW    instruction opcode field
//   cls     out CLS_W  one-hot class: r, lw, sw, branch (beq/ben/bvf), j, addi, illegal
// With ENABLE_ADDI=0 the addi opcode falls through to the illegal class.
module opcode_class_decoder
    import ctrl_pkg::*;
#(
    parameter int OPW         = 6,
    parameter int ENABLE_ADDI = 1
) (
    input  logic [OPW-1:0]   opcode,
    output logic [CLS_W-1:0] cls
);

    always_comb begin
        cls = '0;
        if (opcode == OPW'(OP_R))
            cls[CLS_R] = 1'b1;
        else if (opcode == OPW'(OP_LW))
            cls[CLS_LW] = 1'b1;
        else if (opcode == OPW'(OP_SW))
            cls[CLS_SW] = 1'b1;
        else if (opcode == OPW'(OP_BEQ) || opcode == OPW'(OP_BEN) || opcode == OPW'(OP_BVF))
            cls[CLS_BR] = 1'b1;
        else if (opcode == OPW'(OP_J))
            cls[CLS_J] = 1'b1;
        else if ((ENABLE_ADDI != 0) && opcode == OPW'(OP_ADDI))
            cls[CLS_ADDI] = 1'b1;
        else
            cls[CLS_ILL] = 1'b1;
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle main-control FSM for the shared-memory MIPS-like datapath.
// Sequences fetch/decode/execute/mem/writeback, waits on mem_ready, traps
// (or skips) illegal opcodes and counts retired instructions.
// Ports:
//   clk, reset (async, active-high)
//   opcode [OPW]     IR[31:26], stable from DECODE until the return to FETCH
//   mem_ready        memory access completes this cycle
//   pcwrite, pcwritecond, iord, irwrite, memread, memwrite, memtoreg,
//   regwrite, regdst, alusrca                        datapath strobes/selects
//   alusrcb[2], aluop[2], pcsource[2]                datapath mux/ALU selects
//   bcond_sel[2]     branch condition (zero/negative/overflow), latched in DECODE
//   illegal          illegal-opcode flag
//   state[4]         current state (debug)
//   retired[CNTW]    retired-instruction count, wraps
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int OPW         = 6,
    parameter int CNTW        = 32,
    parameter int ENABLE_ADDI = 1,
    parameter int MEM_WAIT    = 1,
    parameter int TRAP_ON_ILL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            mem_ready,
    output logic            pcwrite,
    output logic            pcwritecond,
    output logic            iord,
    output logic            irwrite,
    output logic            memread,
    output logic            memwrite,
    output logic            memtoreg,
    output logic            regwrite,
    output logic            regdst,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      aluop,
    output logic [1:0]      pcsource,
    output logic [1:0]      bcond_sel,
    output logic            illegal,
    output logic [3:0]      state,
    output logic [CNTW-1:0] retired
);

    state_t           cur;
    state_t           nxt;
    ctrl_t            ctl;
    logic [CLS_W-1:0] cls;
    logic             rdy;
    logic             retire;
    logic [1:0]       bc_dec;

    assign rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;

    opcode_class_decoder #(
        .OPW         (OPW),
        .ENABLE_ADDI (ENABLE_ADDI)
    ) u_dec (
        .opcode (opcode),
        .cls    (cls)
    );

    always_comb begin
        if (opcode == OPW'(OP_BEN))
            bc_dec = BC_NEG;
        else if (opcode == OPW'(OP_BVF))
            bc_dec = BC_OVF;
        else
            bc_dec = BC_ZERO;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH:  if (rdy) nxt = S_DECODE;
            S_DECODE: begin
                if (cls[CLS_LW] || cls[CLS_SW]) nxt = S_MEMADR;
                else if (cls[CLS_R])            nxt = S_REXEC;
                else if (cls[CLS_BR])           nxt = S_BRANCH;
                else if (cls[CLS_J])            nxt = S_JUMP;
                else if (cls[CLS_ADDI])         nxt = S_ADDIEX;
                else                            nxt = (TRAP_ON_ILL != 0) ? S_TRAP : S_FETCH;
            end
            S_MEMADR: nxt = cls[CLS_LW] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (rdy) nxt = S_MEMWB;
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR:  if (rdy) nxt = S_FETCH;
            S_REXEC:  nxt = S_RWB;
            S_RWB:    nxt = S_FETCH;
            S_ADDIEX: nxt = S_ADDIWB;
            S_ADDIWB: nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_IDLE;
        endcase
    end

    // An instruction retires on the edge that leaves its last state for FETCH.
    // The illegal-NOP path (DECODE -> FETCH) is deliberately not counted.
    always_comb begin
        case (cur)
            S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEMWR: retire = rdy;
            default: retire = 1'b0;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the
    // state register and carry no decode glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= S_IDLE;
            ctl       <= '0;
            bcond_sel <= BC_ZERO;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            cur <= nxt;
            ctl <= state_outputs(nxt);
            if (cur == S_DECODE)
                bcond_sel <= bc_dec;
            // Sticky while trapped; otherwise a one-cycle pulse on the FETCH
            // that follows an illegal DECODE.
            illegal <= (nxt == S_TRAP) ||
                       ((cur == S_DECODE) && cls[CLS_ILL] && (TRAP_ON_ILL == 0));
            if (retire)
                retired <= retired + CNTW'(1);
        end
    end

    assign irwrite     = ctl.fetch & rdy;
    assign pcwrite     = ctl.pcwrite | (ctl.fetch & rdy);
    assign pcwritecond = ctl.pcwritecond;
    assign iord        = ctl.iord;
    assign memread     = ctl.memread;
    assign memwrite    = ctl.memwrite;
    assign memtoreg    = ctl.memtoreg;
    assign regwrite    = ctl.regwrite;
    assign regdst      = ctl.regdst;
    assign alusrca     = ctl.alusrca;
    assign alusrcb     = ctl.alusrcb;
    assign aluop       = ctl.aluop;
    assign pcsource    = ctl.pcsource;
    assign state       = cur;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm. Two instances: the default configuration,
// and one with ENABLE_ADDI=0 / TRAP_ON_ILL=0 for the addi-illegal and NOP-illegal paths.
// Each issued instruction pushes its expected latency and retired count onto a
// queue; a negedge monitor pops and compares whenever the DUT retires.
module tb_multicycle_control_fsm;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd6;
    localparam logic [3:0] ST_BRANCH = 4'd11;
    localparam logic [3:0] ST_TRAP   = 4'd13;

    localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
    localparam logic [5:0] BEQ_OP = 6'b000100, BEN_OP = 6'b000110, BVF_OP = 6'b000101;
    localparam logic [5:0] J_OP = 6'b000010, ADDI_OP = 6'b001000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_ready;
    logic [5:0]  opcode;
    logic        pcwrite, pcwritecond, iord, irwrite, memread, memwrite, memtoreg, regwrite, regdst, alusrca;
    logic [1:0]  alusrcb, aluop, pcsource, bcond_sel;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        reset2, mem_ready2;
    logic [5:0]  opcode2;
    logic        pcwrite2, pcwritecond2, iord2, irwrite2, memread2, memwrite2, memtoreg2, regwrite2, regdst2, alusrca2;
    logic [1:0]  alusrcb2, aluop2, pcsource2, bcond_sel2;
    logic        illegal2;
    logic [3:0]  state2;
    logic [31:0] retired2;

    multicycle_control_fsm u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .irwrite(irwrite),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite),
        .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsource(pcsource), .bcond_sel(bcond_sel), .illegal(illegal), .state(state),
        .retired(retired)
    );

    multicycle_control_fsm #(.ENABLE_ADDI(0), .TRAP_ON_ILL(0)) u_dut2 (
        .clk(clk), .reset(reset2), .opcode(opcode2), .mem_ready(mem_ready2),
        .pcwrite(pcwrite2), .pcwritecond(pcwritecond2), .iord(iord2), .irwrite(irwrite2),
        .memread(memread2), .memwrite(memwrite2), .memtoreg(memtoreg2), .regwrite(regwrite2),
        .regdst(regdst2), .alusrca(alusrca2), .alusrcb(alusrcb2), .aluop(aluop2),
        .pcsource(pcsource2), .bcond_sel(bcond_sel2), .illegal(illegal2), .state(state2),
        .retired(retired2)
    );

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    typedef struct { int lat; int ret; } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ctlvec();
        return {pcwrite, pcwritecond, iord, irwrite, memread, memwrite, memtoreg,
                regwrite, regdst, alusrca, alusrcb, aluop, pcsource};
    endfunction

    // Everything except the mem_ready-qualified fetch strobes.
    function automatic logic [31:0] waitvec();
        return {12'd0, state, pcwritecond, iord, memread, memwrite, memtoreg, regwrite,
                regdst, alusrca, alusrcb, aluop, pcsource, bcond_sel, illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency is counted from the first FETCH cycle of an instruction
    // to the first FETCH cycle of the next one.
    int         mon_cnt = 0;
    logic [3:0] prev_st = 4'd0;
    logic [31:0] prev_ret = 32'd0;
    exp_t       mon_e;
    always @(negedge clk) begin
        chk("regwrite_memwrite_excl", {63'd0, regwrite & memwrite}, 64'd0);
        chk("pcwrite_pcwritecond_excl", {63'd0, pcwrite & pcwritecond}, 64'd0);
        if (state == ST_FETCH && prev_st != ST_FETCH) begin
            if (retired != prev_ret) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: got retired=%0d expected no retirement", retired);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("latency", 64'(mon_cnt), 64'(mon_e.lat));
                    chk("retired_count", 64'(retired), 64'(mon_e.ret));
                end
            end
            mon_cnt = 1;
        end else begin
            mon_cnt++;
        end
        prev_st  = state;
        prev_ret = retired;
    end

    // Called in the first FETCH cycle; returns in the first FETCH cycle of the
    // next instruction. fw/mw are wait cycles in FETCH and in MEMRD/MEMWR.
    task automatic do_instr(input logic [5:0] op, input int fw, input int mw,
                            input int lat, input logic [1:0] bc);
        int fwl, mwl;
        bit left, done, waited;
        logic [31:0] snap;
        fwl = fw; mwl = mw; left = 0; done = 0; waited = 0; snap = '0;
        exp_ret++;
        exp_q.push_back('{lat: lat, ret: exp_ret});
        opcode = op;
        for (int n = 0; n < 60; n++) begin
            if (waited)
                chk("wait_stable", {32'd0, waitvec()}, {32'd0, snap});
            if (state == ST_FETCH && fwl > 0) begin
                mem_ready = 1'b0; fwl--; waited = 1; snap = waitvec();
            end else if ((state == ST_MEMRD || state == ST_MEMWR) && mwl > 0) begin
                mem_ready = 1'b0; mwl--; waited = 1; snap = waitvec();
            end else begin
                mem_ready = 1'b1; waited = 0;
            end
            if (state == ST_BRANCH) begin
                chk("branch_bcond_sel", {62'd0, bcond_sel}, {62'd0, bc});
                chk("branch_pcwritecond", {63'd0, pcwritecond}, 64'd1);
                chk("branch_pcsource", {62'd0, pcsource}, 64'd1);
                chk("branch_pcwrite", {63'd0, pcwrite}, 64'd0);
            end
            step();
            if (state != ST_FETCH) left = 1;
            else if (left) begin done = 1; break; end
        end
        mem_ready = 1'b1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL instr_timeout: got no return to FETCH for opcode %b within 60 cycles", op);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; reset2 = 1'b1; opcode = R_OP; opcode2 = R_OP;
        mem_ready = 1'b1; mem_ready2 = 1'b1;
        repeat (2) step();
        chk("rst_state", {60'd0, state}, {60'd0, ST_IDLE});
        chk("rst_ctl", {48'd0, ctlvec()}, 64'd0);
        chk("rst_retired", {32'd0, retired}, 64'd0);
        chk("rst_bcond_illegal", {61'd0, bcond_sel, illegal}, 64'd0);

        reset = 1'b0;
        chk("idle_after_release", {60'd0, state}, {60'd0, ST_IDLE});
        step();
        chk("first_fetch_state", {60'd0, state}, {60'd0, ST_FETCH});
        chk("first_fetch_memread", {63'd0, memread}, 64'd1);
        chk("first_fetch_irwrite", {63'd0, irwrite}, 64'd1);
        chk("first_fetch_alusrcb", {62'd0, alusrcb}, 64'd1);

        do_instr(R_OP,    0, 0, 4, 2'b00);
        do_instr(LW_OP,   0, 0, 5, 2'b00);
        do_instr(SW_OP,   0, 0, 4, 2'b00);
        do_instr(ADDI_OP, 0, 0, 4, 2'b00);
        do_instr(BEQ_OP,  0, 0, 3, 2'b00);
        do_instr(J_OP,    0, 0, 3, 2'b00);
        chk("retired_after_six", {32'd0, retired}, 64'd6);

        do_instr(LW_OP,   2, 3, 10, 2'b00);
        do_instr(BEN_OP,  0, 0, 3, 2'b01);
        do_instr(BVF_OP,  0, 0, 3, 2'b10);
        chk("retired_after_nine", {32'd0, retired}, 64'd9);

        // Reset in the middle of a load.
        opcode = LW_OP;
        step(); step(); step();
        chk("midlw_state", {60'd0, state}, {60'd0, ST_MEMRD});
        chk("midlw_memread_iord", {62'd0, memread, iord}, 64'd3);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        exp_ret = 0;
        chk("abort_state", {60'd0, state}, {60'd0, ST_IDLE});
        chk("abort_ctl", {48'd0, ctlvec()}, 64'd0);
        chk("abort_retired", {32'd0, retired}, 64'd0);
        repeat (3) step();
        reset = 1'b0; mem_ready = 1'b1; opcode = R_OP;
        chk("abort_idle_after_release", {60'd0, state}, {60'd0, ST_IDLE});
        step();
        chk("abort_fetch_state", {60'd0, state}, {60'd0, ST_FETCH});
        chk("abort_fetch_memread", {63'd0, memread}, 64'd1);
        chk("abort_fetch_retired", {32'd0, retired}, 64'd0);

        // Illegal opcode with trapping enabled.
        do_instr(R_OP, 0, 0, 4, 2'b00);
        opcode = 6'b111111;
        step();
        chk("trap_decode", {60'd0, state}, {60'd0, ST_DECODE});
        for (int i = 0; i < 4; i++) begin
            step();
            chk("trap_state", {60'd0, state}, {60'd0, ST_TRAP});
            chk("trap_illegal", {63'd0, illegal}, 64'd1);
            chk("trap_ctl", {48'd0, ctlvec()}, 64'd0);
            chk("trap_retired", {32'd0, retired}, 64'd1);
        end
        reset = 1'b1;
        #1;
        chk("trap_clear_state", {60'd0, state}, {60'd0, ST_IDLE});
        chk("trap_clear_illegal", {63'd0, illegal}, 64'd0);
        chk("trap_clear_retired", {32'd0, retired}, 64'd0);

        // Second instance: addi disabled, illegal treated as NOP.
        step();
        reset2 = 1'b0; opcode2 = ADDI_OP;
        chk("d2_idle", {60'd0, state2}, {60'd0, ST_IDLE});
        step();
        chk("d2_fetch", {60'd0, state2}, {60'd0, ST_FETCH});
        chk("d2_fetch_illegal", {63'd0, illegal2}, 64'd0);
        step();
        chk("d2_decode", {60'd0, state2}, {60'd0, ST_DECODE});
        step();
        chk("d2_nop_state", {60'd0, state2}, {60'd0, ST_FETCH});
        chk("d2_nop_illegal", {63'd0, illegal2}, 64'd1);
        chk("d2_nop_retired", {32'd0, retired2}, 64'd0);
        opcode2 = R_OP;
        step();
        chk("d2_pulse_end_state", {60'd0, state2}, {60'd0, ST_DECODE});
        chk("d2_pulse_end_illegal", {63'd0, illegal2}, 64'd0);
        step(); step(); step();
        chk("d2_resume_state", {60'd0, state2}, {60'd0, ST_FETCH});
        chk("d2_resume_retired", {32'd0, retired2}, 64'd1);
        chk("d2_resume_illegal", {63'd0, illegal2}, 64'd0);

        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
